// File: rtl/sensor_input_conditioner.sv
// Input front end: synchronises and debounces the seven raw sensor/selector pins,
// reports stable levels with one-cycle change strobes, and decodes the water-level sensors.
module sensor_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned COUNT_WIDTH     = 19
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] sensor_raw,
    output logic [6:0] sensor_stable,
    output logic [6:0] sensor_changed,
    output logic [1:0] encoded_water,
    output logic       conflicting_values
);

    localparam int unsigned NUM_BITS = 7;
    localparam logic [COUNT_WIDTH-1:0] CNT_LAST = COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
        $error("sensor_input_conditioner: DEBOUNCE_CYCLES must be >= 1");
    end
    if ((64'd1 << COUNT_WIDTH) < 64'(DEBOUNCE_CYCLES)) begin : g_bad_width
        $error("sensor_input_conditioner: COUNT_WIDTH too small for DEBOUNCE_CYCLES");
    end

    logic [NUM_BITS-1:0]    sync1;
    logic [NUM_BITS-1:0]    synced;
    logic [COUNT_WIDTH-1:0] cnt      [NUM_BITS];
    logic [COUNT_WIDTH-1:0] cnt_next [NUM_BITS];
    logic [NUM_BITS-1:0]    stable_next;
    logic [NUM_BITS-1:0]    changed_next;

    // Two-flop synchroniser on every pin.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1  <= '0;
            synced <= '0;
        end else begin
            sync1  <= sensor_raw;
            synced <= sync1;
        end
    end

    // Per-bit debounce: a differing level must persist DEBOUNCE_CYCLES synced cycles.
    always_comb begin
        stable_next  = sensor_stable;
        changed_next = '0;
        for (int i = 0; i < int'(NUM_BITS); i++) begin
            cnt_next[i] = '0;
            if (synced[i] != sensor_stable[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    stable_next[i]  = synced[i];
                    changed_next[i] = 1'b1;
                end else begin
                    cnt_next[i] = cnt[i] + COUNT_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sensor_stable  <= '0;
            sensor_changed <= '0;
            for (int i = 0; i < int'(NUM_BITS); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sensor_stable  <= stable_next;
            sensor_changed <= changed_next;
            for (int i = 0; i < int'(NUM_BITS); i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    // Water decode; the last legal level is held while the sensors disagree.
    always_ff @(posedge clock) begin
        if (reset) begin
            encoded_water      <= 2'd0;
            conflicting_values <= 1'b0;
        end else begin
            case (sensor_stable[2:0])
                3'b000: begin
                    encoded_water      <= 2'd0;
                    conflicting_values <= 1'b0;
                end
                3'b001: begin
                    encoded_water      <= 2'd1;
                    conflicting_values <= 1'b0;
                end
                3'b011: begin
                    encoded_water      <= 2'd2;
                    conflicting_values <= 1'b0;
                end
                3'b111: begin
                    encoded_water      <= 2'd3;
                    conflicting_values <= 1'b0;
                end
                default: conflicting_values <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_input_conditioner.sv
// Bench for sensor_input_conditioner: window-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_sensor_input_conditioner;

    localparam int unsigned N = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] sensor_raw = 7'h00;
    logic [6:0] sensor_stable;
    logic [6:0] sensor_changed;
    logic [1:0] encoded_water;
    logic       conflicting_values;

    int checks = 0;
    int errors = 0;

    sensor_input_conditioner #(
        .DEBOUNCE_CYCLES(N),
        .COUNT_WIDTH    (3)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .sensor_raw        (sensor_raw),
        .sensor_stable     (sensor_stable),
        .sensor_changed    (sensor_changed),
        .encoded_water     (encoded_water),
        .conflicting_values(conflicting_values)
    );

    always #5 clock = ~clock;

    // Model: hist[k] is the raw value sampled k+1 edges before the edge being evaluated.
    // A bit flips when the raw samples taken 2..N+1 edges earlier all differ from its stable level.
    logic [6:0] hist [N+1];
    logic [6:0] m_stable, m_changed, m_stable_n, m_changed_n, all_diff;
    logic [1:0] m_enc, m_enc_n;
    logic       m_conf, m_conf_n;
    logic       model_live = 1'b0;

    always_comb begin
        all_diff    = '1;
        m_stable_n  = m_stable;
        m_changed_n = '0;
        for (int b = 0; b < 7; b++) begin
            for (int k = 1; k <= int'(N); k++) begin
                if (hist[k][b] == m_stable[b]) all_diff[b] = 1'b0;
            end
            if (all_diff[b]) begin
                m_stable_n[b]  = ~m_stable[b];
                m_changed_n[b] = 1'b1;
            end
        end
        m_enc_n  = m_enc;
        m_conf_n = 1'b1;
        if (m_stable[2:0] == 3'b000) begin m_enc_n = 2'd0; m_conf_n = 1'b0; end
        if (m_stable[2:0] == 3'b001) begin m_enc_n = 2'd1; m_conf_n = 1'b0; end
        if (m_stable[2:0] == 3'b011) begin m_enc_n = 2'd2; m_conf_n = 1'b0; end
        if (m_stable[2:0] == 3'b111) begin m_enc_n = 2'd3; m_conf_n = 1'b0; end
    end

    always @(posedge clock) begin
        model_live <= 1'b1;
        if (reset) begin
            m_stable  <= '0;
            m_changed <= '0;
            m_enc     <= 2'd0;
            m_conf    <= 1'b0;
            for (int k = 0; k <= int'(N); k++) hist[k] <= '0;
        end else begin
            m_stable  <= m_stable_n;
            m_changed <= m_changed_n;
            m_enc     <= m_enc_n;
            m_conf    <= m_conf_n;
            hist[0]   <= sensor_raw;
            for (int k = 1; k <= int'(N); k++) hist[k] <= hist[k-1];
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (model_live) begin
            check("model_stable",   32'(sensor_stable),      32'(m_stable));
            check("model_changed",  32'(sensor_changed),     32'(m_changed));
            check("model_water",    32'(encoded_water),      32'(m_enc));
            check("model_conflict", 32'(conflicting_values), 32'(m_conf));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // 1: all pins high through reset, accepted on E5, decoded on E6
        sensor_raw = 7'h7F;
        ticks(3);
        check("reset_stable",  32'(sensor_stable),  32'h00);
        check("reset_changed", 32'(sensor_changed), 32'h00);
        check("reset_water",   32'(encoded_water),  32'h0);
        reset = 1'b0;
        for (int j = 1; j <= 7; j++) begin
            tick();
            if (j == 5) check("t1_stable_E4", 32'(sensor_stable), 32'h00);
            if (j == 6) begin
                check("t1_stable_E5",  32'(sensor_stable),  32'h7F);
                check("t1_changed_E5", 32'(sensor_changed), 32'h7F);
                check("t1_water_E5",   32'(encoded_water),  32'h0);
            end
            if (j == 7) begin
                check("t1_changed_E6",  32'(sensor_changed),     32'h00);
                check("t1_water_E6",    32'(encoded_water),      32'h3);
                check("t1_conflict_E6", 32'(conflicting_values), 32'h0);
            end
        end
        sensor_raw = 7'h00;
        ticks(8);
        check("t1_cleared", 32'(sensor_stable), 32'h00);

        // 2: 3-cycle glitch on bit 3 is rejected
        sensor_raw = 7'h08;
        ticks(3);
        sensor_raw = 7'h00;
        for (int j = 0; j < 10; j++) begin
            tick();
            check("t2_stable",  32'(sensor_stable),  32'h00);
            check("t2_changed", 32'(sensor_changed), 32'h00);
        end

        // 3: bit 4 chatters then settles high; single pulse 5 edges after settling
        for (int i = 0; i < 12; i++) begin
            sensor_raw = ((i / 2) % 2 == 0) ? 7'h10 : 7'h00;
            tick();
            check("t3_chatter_changed", 32'(sensor_changed), 32'h00);
        end
        sensor_raw = 7'h10;
        for (int j = 1; j <= 9; j++) begin
            tick();
            if (j < 6) check("t3_stable_pre", 32'(sensor_stable), 32'h00);
            if (j == 6) begin
                check("t3_stable_E5",  32'(sensor_stable),  32'h10);
                check("t3_changed_E5", 32'(sensor_changed), 32'h10);
            end else begin
                check("t3_no_pulse", 32'(sensor_changed), 32'h00);
            end
        end
        sensor_raw = 7'h00;
        ticks(8);

        // 4: water decode, conflict with held level, recovery
        sensor_raw = 7'h03;
        ticks(8);
        check("t4_water_mid", 32'(encoded_water),      32'h2);
        check("t4_conf_mid",  32'(conflicting_values), 32'h0);
        sensor_raw = 7'h05;
        for (int j = 1; j <= 7; j++) begin
            tick();
            if (j == 6) begin
                check("t4_stable_101",  32'(sensor_stable),      32'h05);
                check("t4_conf_E5",     32'(conflicting_values), 32'h0);
            end
            if (j == 7) begin
                check("t4_conf_E6",  32'(conflicting_values), 32'h1);
                check("t4_hold_mid", 32'(encoded_water),      32'h2);
            end
        end
        sensor_raw = 7'h07;
        ticks(7);
        check("t4_conf_clear", 32'(conflicting_values), 32'h0);
        check("t4_water_high", 32'(encoded_water),      32'h3);
        sensor_raw = 7'h00;
        ticks(8);
        check("t4_water_empty", 32'(encoded_water), 32'h0);

        // 5: reset mid-count discards progress
        sensor_raw = 7'h01;
        ticks(3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_stable_rst",  32'(sensor_stable),  32'h00);
        check("t5_changed_rst", 32'(sensor_changed), 32'h00);
        for (int j = 1; j <= 6; j++) begin
            tick();
            if (j == 5) check("t5_stable_E4", 32'(sensor_stable), 32'h00);
            if (j == 6) begin
                check("t5_stable_E5",  32'(sensor_stable),  32'h01);
                check("t5_changed_E5", 32'(sensor_changed), 32'h01);
            end
        end
        sensor_raw = 7'h00;
        ticks(8);

        // 6: two channels accepted on the same edge
        sensor_raw = 7'h60;
        ticks(5);
        check("t6_changed_pre", 32'(sensor_changed), 32'h00);
        tick();
        check("t6_changed", 32'(sensor_changed), 32'h60);
        check("t6_stable",  32'(sensor_stable),  32'h60);
        tick();
        check("t6_changed_post", 32'(sensor_changed), 32'h00);
        ticks(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
